// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: control bundle layout,
// bubble encoding and opcodes shared with the Control unit.
package pipeline_pkg;
    localparam int CTRL_W = 10;

    localparam int CTRL_REGDEST  = 9;
    localparam int CTRL_BRANCH   = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_ALUOP1   = 5;
    localparam int CTRL_ALUOP2   = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_JUMP     = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 10'b0;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;
endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. Register $0 never produces a hazard.
module load_use_detect
    import pipeline_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             uses_rs,
    input  logic             uses_rt,
    output logic             hazard
);
    assign hazard = ex_mem_read && (ex_rt != '0) &&
                    ((uses_rs && (ex_rt == id_rs)) || (uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion
// on hazard or flush, and a saturating stall-cycle counter.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] pc4_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              flush,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] pc4_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic uses_rs, uses_rt, hazard, bubble;

    // Jumps read no register; stores read rt even though ALUSrc selects imm.
    assign uses_rs = !ctrl_in[CTRL_JUMP];
    assign uses_rt = !ctrl_in[CTRL_ALUSRC] || ctrl_in[CTRL_MEMWRITE];

    load_use_detect #(.REG_W(REG_W)) u_detect (
        .ex_mem_read (ctrl_out[CTRL_MEMREAD]),
        .ex_rt       (rt_out),
        .id_rs       (rs_in),
        .id_rt       (rt_in),
        .uses_rs     (uses_rs),
        .uses_rt     (uses_rt),
        .hazard      (hazard)
    );

    // A flushed instruction is discarded anyway, so there is nothing to hold.
    assign stall  = hazard && !flush;
    assign bubble = flush || hazard;

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ctrl_out <= CTRL_BUBBLE;
            pc4_out  <= '0;
            rd1_out  <= '0;
            rd2_out  <= '0;
            imm_out  <= '0;
            rs_out   <= '0;
            rt_out   <= '0;
            rd_out   <= '0;
        end else begin
            ctrl_out <= ctrl_in;
            pc4_out  <= pc4_in;
            rd1_out  <= rd1_in;
            rd2_out  <= rd2_in;
            imm_out  <= imm_in;
            rs_out   <= rs_in;
            rt_out   <= rt_in;
            rd_out   <= rd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_id_ex_stage;
    localparam logic [9:0] C_ADD  = 10'b1000100010;
    localparam logic [9:0] C_LW   = 10'b0011000110;
    localparam logic [9:0] C_SW   = 10'b0000001100;
    localparam logic [9:0] C_ADDI = 10'b0000000110;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  ctrl_in;
    logic [31:0] pc4_in, rd1_in, rd2_in, imm_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic        flush;

    logic [9:0]  ctrl_out, s_ctrl_out;
    logic [31:0] pc4_out, rd1_out, rd2_out, imm_out;
    logic [31:0] s_pc4_out, s_rd1_out, s_rd2_out, s_imm_out;
    logic [4:0]  rs_out, rt_out, rd_out, s_rs_out, s_rt_out, s_rd_out;
    logic        stall, s_stall;
    logic [15:0] stall_cnt;
    logic [1:0]  s_stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .pc4_in(pc4_in),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
        .ctrl_out(ctrl_out), .pc4_out(pc4_out), .rd1_out(rd1_out),
        .rd2_out(rd2_out), .imm_out(imm_out), .rs_out(rs_out),
        .rt_out(rt_out), .rd_out(rd_out), .stall(stall), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .pc4_in(pc4_in),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
        .ctrl_out(s_ctrl_out), .pc4_out(s_pc4_out), .rd1_out(s_rd1_out),
        .rd2_out(s_rd2_out), .imm_out(s_imm_out), .rs_out(s_rs_out),
        .rt_out(s_rt_out), .rd_out(s_rd_out), .stall(s_stall), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc4, input logic fl);
        ctrl_in = c; rs_in = rs; rt_in = rt; rd_in = rd;
        rd1_in = d1; rd2_in = d2; imm_in = imm; pc4_in = pc4; flush = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ctrl"}, 64'(ctrl_out), 64'(0));
        chk({tag, ".data"}, 64'({pc4_out, rd1_out} | {rd2_out, imm_out}), 64'(0));
        chk({tag, ".regs"}, 64'({rs_out, rt_out, rd_out}), 64'(0));
    endtask

    initial begin
        reset = 1'b1;
        drive(10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom, $urandom, $urandom, $urandom, 1'b0);
        tick();
        drive(10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom, $urandom, $urandom, $urandom, 1'b0);
        tick();
        chk_zero("reset");
        chk("reset.stall", 64'(stall), 64'(0));
        chk("reset.cnt", 64'(stall_cnt), 64'(0));
        chk("reset.cnt_sat", 64'(s_stall_cnt), 64'(0));
        reset = 1'b0;

        // add $3,$1,$2 passes through
        drive(C_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 32'h4, 1'b0);
        chk("pass.stall", 64'(stall), 64'(0));
        tick();
        chk("pass.ctrl", 64'(ctrl_out), 64'(C_ADD));
        chk("pass.rd1", 64'(rd1_out), 64'd5);
        chk("pass.rd2", 64'(rd2_out), 64'd7);
        chk("pass.regs", 64'({rs_out, rt_out, rd_out}), 64'({5'd1, 5'd2, 5'd3}));
        chk("pass.pc4", 64'(pc4_out), 64'h4);

        // lw $2 then dependent add
        drive(C_LW, 5'd1, 5'd2, 5'd0, 32'h10, 32'h0, 32'h8, 32'h8, 1'b0);
        chk("lw.stall", 64'(stall), 64'(0));
        tick();
        chk("lw.ctrl", 64'(ctrl_out), 64'(C_LW));
        drive(C_ADD, 5'd2, 5'd3, 5'd4, 32'h11, 32'h22, 32'h0, 32'hC, 1'b0);
        chk("lu.stall", 64'(stall), 64'(1));
        tick();
        chk_zero("lu.bubble");
        chk("lu.cnt", 64'(stall_cnt), 64'd1);
        chk("lu.stall_after", 64'(stall), 64'(0));
        tick();
        chk("lu.capture", 64'(ctrl_out), 64'(C_ADD));
        chk("lu.rs", 64'(rs_out), 64'd2);
        chk("lu.rd2", 64'(rd2_out), 64'h22);

        // lw $0 then add rs=0: no hazard
        drive(C_LW, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h4, 32'h10, 1'b0);
        tick();
        drive(C_ADD, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 32'h14, 1'b0);
        chk("r0.stall", 64'(stall), 64'(0));
        tick();

        // lw $4 then addi rt=4: rt unused
        drive(C_LW, 5'd1, 5'd4, 5'd0, 32'h0, 32'h0, 32'h4, 32'h18, 1'b0);
        tick();
        drive(C_ADDI, 5'd1, 5'd4, 5'd0, 32'h0, 32'h0, 32'h1, 32'h1C, 1'b0);
        chk("addi.stall", 64'(stall), 64'(0));
        tick();
        chk("addi.ctrl", 64'(ctrl_out), 64'(C_ADDI));

        // lw $4 then sw rt=4: store data is a use
        drive(C_LW, 5'd1, 5'd4, 5'd0, 32'h0, 32'h0, 32'h4, 32'h20, 1'b0);
        tick();
        drive(C_SW, 5'd1, 5'd4, 5'd0, 32'h0, 32'h0, 32'h8, 32'h24, 1'b0);
        chk("sw.stall", 64'(stall), 64'(1));
        tick();
        chk("sw.ctrl", 64'(ctrl_out), 64'(0));
        chk("sw.cnt", 64'(stall_cnt), 64'd2);
        tick();
        chk("sw.capture", 64'(ctrl_out), 64'(C_SW));

        // flush overrides a load-use hazard
        drive(C_LW, 5'd1, 5'd6, 5'd0, 32'h0, 32'h0, 32'h4, 32'h28, 1'b0);
        tick();
        drive(C_ADD, 5'd6, 5'd1, 5'd7, 32'h3, 32'h4, 32'h0, 32'h2C, 1'b1);
        chk("flush_hz.stall", 64'(stall), 64'(0));
        tick();
        chk_zero("flush_hz.bubble");
        chk("flush_hz.cnt", 64'(stall_cnt), 64'd2);
        drive(C_ADD, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 32'h30, 1'b1);
        tick();
        chk_zero("flush.bubble");
        chk("flush.cnt", 64'(stall_cnt), 64'd2);

        // reset during a stall cycle
        drive(C_LW, 5'd1, 5'd7, 5'd0, 32'h0, 32'h0, 32'h4, 32'h34, 1'b0);
        tick();
        drive(C_ADD, 5'd7, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 32'h38, 1'b0);
        chk("rst_mid.stall_pre", 64'(stall), 64'(1));
        reset = 1'b1;
        tick();
        chk_zero("rst_mid");
        chk("rst_mid.stall", 64'(stall), 64'(0));
        chk("rst_mid.cnt", 64'(stall_cnt), 64'(0));
        reset = 1'b0;
        tick();
        chk("rst_mid.resume", 64'(ctrl_out), 64'(C_ADD));

        // five lw/dependent pairs: 16-bit counter reaches 5, 2-bit saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(C_LW, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'h40, 1'b0);
            tick();
            drive(C_ADD, 5'd2, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 32'h44, 1'b0);
            tick();
        end
        chk("sat.cnt16", 64'(stall_cnt), 64'd5);
        chk("sat.cnt2", 64'(s_stall_cnt), 64'd3);
        tick();
        drive(C_LW, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'h48, 1'b0);
        tick();
        drive(C_ADD, 5'd2, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 32'h4C, 1'b0);
        chk("sat.stall", 64'(s_stall), 64'(1));
        tick();
        chk("sat.hold16", 64'(stall_cnt), 64'd6);
        chk("sat.hold2", 64'(s_stall_cnt), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
